// File: rtl/reg_dump_reader.sv
// Read-side scan engine for the 16x8 register file: walks an inclusive (wrapping) register
// range over the operand-read port and streams each byte on a valid/ready port.
// Optional trailing XOR checksum byte when REGDUMP_CSUM_EN is defined.
module reg_dump_reader #(
    parameter int pw = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [pw-1:0] first_addr,
    input  logic [pw-1:0] last_addr,
    output logic [pw:0]   rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

`ifdef REGDUMP_CSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;
    logic [7:0] checksum;
`else
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

    state_t        state;
    logic [pw-1:0] ptr;
    logic [pw-1:0] last_q;
    logic          at_last;
    logic [pw-1:0] ptr_next;

    assign at_last  = (ptr == last_q);
    assign ptr_next = ptr + 1'b1;

    // rd_addr is registered alongside ptr so it already equals ptr throughout FETCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            last_q    <= '0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REGDUMP_CSUM_EN
            checksum  <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout; every register here is updated from pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr     <= first_addr;
                        last_q  <= last_addr;
                        rd_addr <= {1'b0, first_addr};
                        busy    <= 1'b1;
`ifdef REGDUMP_CSUM_EN
                        checksum <= '0;
`endif
                        state   <= FETCH;
                    end
                end

                FETCH: begin
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
`ifdef REGDUMP_CSUM_EN
                    out_last  <= 1'b0;
                    checksum  <= checksum ^ rd_data;
`else
                    out_last  <= at_last;
`endif
                    state     <= SEND;
                end

                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (at_last) begin
`ifdef REGDUMP_CSUM_EN
                            // checksum already folds in the byte just accepted
                            out_data  <= checksum;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            state     <= CSUM;
`else
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            ptr     <= ptr_next;
                            rd_addr <= {1'b0, ptr_next};
                            state   <= FETCH;
                        end
                    end
                end

`ifdef REGDUMP_CSUM_EN
                CSUM: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif

                DONE: begin
                    busy    <= 1'b0;
                    rd_addr <= '0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: table of scan ranges plus stall, mid-scan
// interference, reset-abort and (when REGDUMP_CSUM_EN is defined) checksum sequences.
module tb_reg_dump_reader;

`ifdef REGDUMP_CSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] first_addr, last_addr;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last, busy, done;

    logic [7:0] regs [16];
    assign rd_data = regs[rd_addr[3:0]];

    reg_dump_reader #(.pw(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic [3:0] f;
        logic [3:0] l;
        int         n;        // register bytes in range
        logic [7:0] first_b;
        logic [7:0] last_b;   // last register byte
        int         stall_at;
        int         stall_len;
        bit         poke;     // toggle start/first/last while busy
    } vec_t;

    // results of the most recent scan
    logic [7:0] got_d [40];
    logic       got_l [40];
    int         got_n;
    int         stab_err;
    bit         done_seen;
    logic       busy_at_start, busy_after, done_after;
    logic [4:0] rd_addr_after;

    task automatic run_scan(input logic [3:0] f, input logic [3:0] l,
                            input int stall_at, input int stall_len, input bit poke);
        int         cyc = 0;
        int         stalled = 0;
        logic [7:0] hold_d = '0;
        logic       hold_l = 1'b0;
        got_n = 0; stab_err = 0; done_seen = 0;
        first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_at_start = busy;
        while (cyc < 400) begin
            if (done) begin
                done_seen = 1;
                start = 1'b0;
                break;
            end
            out_ready = 1'b1;
            if (got_n == stall_at && stalled < stall_len && out_valid) begin
                out_ready = 1'b0;
                if (stalled == 0) begin
                    hold_d = out_data; hold_l = out_last;
                end else if (out_data !== hold_d || out_last !== hold_l) begin
                    stab_err++;
                end
                stalled++;
            end else if (got_n == stall_at && stalled > 0 && stalled <= stall_len && !out_valid) begin
                stab_err++;
            end
            if (out_valid && out_ready && got_n < 40) begin
                got_d[got_n] = out_data;
                got_l[got_n] = out_last;
                got_n++;
            end
            if (poke) begin
                start      = (cyc % 3 == 0);
                first_addr = 4'($urandom_range(0, 15));
                last_addr  = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        busy_after = busy; done_after = done; rd_addr_after = rd_addr;
    endtask

    task automatic check_scan(input vec_t v, input string tag);
        int         seq_err = 0;
        int         last_err = 0;
        logic [7:0] x = '0;
        logic [7:0] exp_b;
        run_scan(v.f, v.l, v.stall_at, v.stall_len, v.poke);
        for (int i = 0; i < v.n; i++) x ^= regs[4'(int'(v.f) + i)];
        for (int i = 0; i < got_n; i++) begin
            exp_b = (i < v.n) ? regs[4'(int'(v.f) + i)] : x;
            if (got_d[i] !== exp_b) seq_err++;
            if (got_l[i] !== (i == v.n + CSUM - 1)) last_err++;
        end
        check({tag, " busy_at_start"}, busy_at_start, 1);
        check({tag, " byte_count"}, got_n, v.n + CSUM);
        check({tag, " first_byte"}, got_d[0], v.first_b);
        check({tag, " last_reg_byte"}, got_d[v.n-1], v.last_b);
        check({tag, " byte_sequence_errors"}, seq_err, 0);
        check({tag, " out_last_errors"}, last_err, 0);
        check({tag, " stall_stability_errors"}, stab_err, 0);
        check({tag, " done_pulse"}, done_seen, 1);
        check({tag, " busy_after_done"}, busy_after, 0);
        check({tag, " done_one_cycle"}, done_after, 0);
        check({tag, " rd_addr_idle"}, rd_addr_after, 0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{f:4'd0,  l:4'd15, n:16, first_b:8'h10, last_b:8'h1F, stall_at:-1, stall_len:0, poke:0};
        vecs[1] = '{f:4'd14, l:4'd1,  n:4,  first_b:8'h1E, last_b:8'h11, stall_at:-1, stall_len:0, poke:0};
        vecs[2] = '{f:4'd5,  l:4'd5,  n:1,  first_b:8'h15, last_b:8'h15, stall_at:-1, stall_len:0, poke:0};
        vecs[3] = '{f:4'd2,  l:4'd9,  n:8,  first_b:8'h12, last_b:8'h19, stall_at:3,  stall_len:7, poke:0};
        vecs[4] = '{f:4'd15, l:4'd0,  n:2,  first_b:8'h1F, last_b:8'h10, stall_at:-1, stall_len:0, poke:1};
        vecs[5] = '{f:4'd3,  l:4'd2,  n:16, first_b:8'h13, last_b:8'h12, stall_at:0,  stall_len:2, poke:1};

        for (int i = 0; i < 16; i++) regs[i] = 8'(8'h10 + i);
        reset = 1'b0; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_addr", rd_addr, 0);
        check("reset out_data", out_data, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) check_scan(vecs[i], $sformatf("vec%0d", i));

        // Reset while a byte is held in SEND.
        begin
            int   w = 0;
            bit   bad = 0;
            first_addr = 4'd0; last_addr = 4'd15; start = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            while (!out_valid && w < 20) begin
                @(posedge clk); #1; w++;
            end
            check("abort reached_send", out_valid, 1);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            check("abort out_valid", out_valid, 0);
            check("abort busy", busy, 0);
            check("abort rd_addr", rd_addr, 0);
            check("abort done", done, 0);
            out_ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (done || out_valid || busy) bad = 1;
            end
            check("abort stays_idle", bad, 0);
        end
        check_scan('{f:4'd7, l:4'd8, n:2, first_b:8'h17, last_b:8'h18, stall_at:1, stall_len:3, poke:0},
                   "post_abort");

`ifdef REGDUMP_CSUM_EN
        regs[2] = 8'hA5; regs[3] = 8'h0F;
        run_scan(4'd2, 4'd3, -1, 0, 0);
        check("csum byte_count", got_n, 3);
        check("csum byte0", got_d[0], 8'hA5);
        check("csum byte1", got_d[1], 8'h0F);
        check("csum byte2", got_d[2], 8'hAA);
        check("csum last_flags", {got_l[0], got_l[1], got_l[2]}, 3'b001);
        check("csum done_pulse", done_seen, 1);
        regs[2] = 8'h12; regs[3] = 8'h13;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
